// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the shifter arbiter: FSM state encoding and index-width helpers.
package shifter_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ACK       = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Requester index width; never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int IDX_W_DEFAULT   = idx_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/shifter_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first set req bit at or above rr_ptr, wrapping past NUM_REQ-1.
module rr_priority_pick
    import shifter_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   pick,
    output logic               found
);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] offset_sum [NUM_REQ];
    logic [IDX_W-1:0] candidate  [NUM_REQ];

    // candidate[k] is the requester k places after rr_ptr, modulo NUM_REQ
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_candidate
            assign offset_sum[gi] = {1'b0, rr_ptr} + SUM_W'(gi);
            assign candidate[gi]  = (offset_sum[gi] >= SUM_W'(NUM_REQ))
                                  ? IDX_W'(offset_sum[gi] - SUM_W'(NUM_REQ))
                                  : offset_sum[gi][IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[candidate[k]]) begin
                pick  = candidate[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin owner of the shared output shifter; optional watchdog under SHIFTER_ARB_TIMEOUT_EN.
module shifter_arbiter
    import shifter_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IN_WIDTH       = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   req_vector,
    output logic [NUM_REQ-1:0]            ack,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy,
    output logic                          shifter_start,
    output logic [IN_WIDTH-1:0]           shifter_vector,
`ifdef SHIFTER_ARB_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    input  logic                          shifter_done
);
    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("shifter_arbiter: parameter out of range");
    end

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]     grant_reg, grant_next;
    logic [IN_WIDTH-1:0]  vector_reg, vector_next;
    logic                 busy_reg, busy_next;
    logic                 start_reg, start_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic [IDX_W-1:0]     pick;
    logic                 found;
    logic [IDX_W-1:0]     after_owner;
    logic [IN_WIDTH-1:0]  req_slice [NUM_REQ];

`ifdef SHIFTER_ARB_TIMEOUT_EN
    localparam int WD_W = clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0]      wd_reg, wd_next;
    logic                 timeout_reg, timeout_next;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_slice[gi] = req_vector[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .pick   (pick),
        .found  (found)
    );

    assign after_owner = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

    // Outputs are registered: each state's action becomes visible one cycle later,
    // so start shows in the first wait cycle and ack shows while in S_ACK.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        vector_next = vector_reg;
        busy_next   = busy_reg;
        start_next  = 1'b0;
        ack_next    = '0;
`ifdef SHIFTER_ARB_TIMEOUT_EN
        wd_next      = wd_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    grant_next  = pick;
                    vector_next = req_slice[pick];
                    busy_next   = 1'b1;
                    state_next  = S_START;
                end
            end
            S_START: begin
                start_next = 1'b1;
`ifdef SHIFTER_ARB_TIMEOUT_EN
                wd_next    = '0;
`endif
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (shifter_done) begin
                    ack_next    = NUM_REQ'(1) << grant_reg;
                    busy_next   = 1'b0;
                    rr_ptr_next = after_owner;
                    state_next  = S_ACK;
                end
`ifdef SHIFTER_ARB_TIMEOUT_EN
                else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_next = 1'b1;
                    busy_next    = 1'b0;
                    rr_ptr_next  = after_owner;
                    state_next   = S_IDLE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
`endif
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            rr_ptr_reg  <= '0;
            grant_reg   <= '0;
            vector_reg  <= '0;
            busy_reg    <= 1'b0;
            start_reg   <= 1'b0;
            ack_reg     <= '0;
`ifdef SHIFTER_ARB_TIMEOUT_EN
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            grant_reg   <= grant_next;
            vector_reg  <= vector_next;
            busy_reg    <= busy_next;
            start_reg   <= start_next;
            ack_reg     <= ack_next;
`ifdef SHIFTER_ARB_TIMEOUT_EN
            wd_reg      <= wd_next;
            timeout_reg <= timeout_next;
`endif
        end
    end

    assign ack            = ack_reg;
    assign grant_id       = grant_reg;
    assign busy           = busy_reg;
    assign shifter_start  = start_reg;
    assign shifter_vector = vector_reg;
`ifdef SHIFTER_ARB_TIMEOUT_EN
    assign timeout_err    = timeout_reg;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: expected grants/acks queued at stimulus, checked on DUT output.
module tb_shifter_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int IN_WIDTH       = 128;
    localparam int TIMEOUT_CYCLES = 16;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_REQ-1:0]          req = '0;
    logic [NUM_REQ*IN_WIDTH-1:0] req_vector = '0;
    logic [NUM_REQ-1:0]          ack;
    logic [1:0]                  grant_id;
    logic                        busy;
    logic                        shifter_start;
    logic [IN_WIDTH-1:0]         shifter_vector;
    logic                        shifter_done = 1'b0;
`ifdef SHIFTER_ARB_TIMEOUT_EN
    logic                        timeout_err;
`endif

    shifter_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .IN_WIDTH       (IN_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .req_vector     (req_vector),
        .ack            (ack),
        .grant_id       (grant_id),
        .busy           (busy),
        .shifter_start  (shifter_start),
        .shifter_vector (shifter_vector),
`ifdef SHIFTER_ARB_TIMEOUT_EN
        .timeout_err    (timeout_err),
`endif
        .shifter_done   (shifter_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                  id;
        logic [IN_WIDTH-1:0] vec;
    } job_t;

    job_t exp_start_q[$];
    int   exp_ack_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_count = 0;
    int ack_count   = 0;
    int to_count    = 0;
    int last_start_cyc = 0;
    int last_ack_cyc   = 0;
    int last_to_cyc    = 0;
    int done_delay     = 20;
    logic shifter_en   = 1'b1;
    logic [NUM_REQ-1:0] sticky = '0;
    logic busy_q = 1'b0, busy_qq = 1'b0, done_q = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [IN_WIDTH-1:0] obs, input logic [IN_WIDTH-1:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [IN_WIDTH-1:0] vec_of(input int id);
        return {4{32'hC0DE_0000 | 32'(id * 32'h0101)}};
    endfunction

    task automatic push_job(input int id, input logic [IN_WIDTH-1:0] vec, input bit want_ack);
        job_t j;
        j.id  = id;
        j.vec = vec;
        exp_start_q.push_back(j);
        if (want_ack) exp_ack_q.push_back(id);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int i = 0;
        while (start_count < target && i < budget) begin
            tick(1);
            i++;
        end
        if (start_count < target) check({tag, "_expired"}, IN_WIDTH'(start_count), IN_WIDTH'(target));
    endtask

    task automatic wait_acks(input int target, input int budget, input string tag);
        int i = 0;
        while (ack_count < target && i < budget) begin
            tick(1);
            i++;
        end
        if (ack_count < target) check({tag, "_expired"}, IN_WIDTH'(ack_count), IN_WIDTH'(target));
    endtask

    // Simple shifter: answers each start with a done pulse done_delay cycles later.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (shifter_start && shifter_en) begin
                repeat (done_delay) begin
                    @(posedge clock);
                    #1;
                end
                shifter_done = 1'b1;
                @(posedge clock);
                #1;
                shifter_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on start/ack; requesters drop req on their ack unless sticky.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (shifter_start) begin
                    $display("[%0d] start grant_id=%0d vector=%h", cyc, grant_id, shifter_vector);
                    check("start_after_grant", IN_WIDTH'({busy_q, busy_qq}), IN_WIDTH'(2'b10));
                    if (exp_start_q.size() == 0) begin
                        check("start_unexpected", IN_WIDTH'(grant_id), '1);
                    end else begin
                        job_t j;
                        j = exp_start_q.pop_front();
                        check("grant_id", IN_WIDTH'(grant_id), IN_WIDTH'(j.id));
                        check("shifter_vector", shifter_vector, j.vec);
                    end
                    start_count++;
                    last_start_cyc = cyc;
                end
                if (ack != '0) begin
                    $display("[%0d] ack=%b", cyc, ack);
                    check("ack_after_done", IN_WIDTH'(done_q), IN_WIDTH'(1));
                    check("busy_at_ack", IN_WIDTH'(busy), IN_WIDTH'(0));
                    if (exp_ack_q.size() == 0) begin
                        check("ack_unexpected", IN_WIDTH'(ack), '0);
                    end else begin
                        int id;
                        id = exp_ack_q.pop_front();
                        check("ack_onehot", IN_WIDTH'(ack), IN_WIDTH'(1) << id);
                    end
                    ack_count++;
                    last_ack_cyc = cyc;
                end
`ifdef SHIFTER_ARB_TIMEOUT_EN
                if (timeout_err) begin
                    $display("[%0d] timeout_err grant_id=%0d", cyc, grant_id);
                    check("busy_at_timeout", IN_WIDTH'(busy), IN_WIDTH'(0));
                    check("ack_at_timeout", IN_WIDTH'(ack), '0);
                    to_count++;
                    last_to_cyc = cyc;
                end
`endif
            end
            busy_qq = busy_q;
            busy_q  = busy;
            done_q  = shifter_done;
            req     = req & ~(ack & ~sticky);
        end
    end

    initial begin
        int s0, a0, t_start;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_busy", IN_WIDTH'(busy), '0);
        check("rst_ack", IN_WIDTH'(ack), '0);
        check("rst_start", IN_WIDTH'(shifter_start), '0);
        check("rst_grant_id", IN_WIDTH'(grant_id), '0);
        check("rst_vector", shifter_vector, '0);
        reset = 1'b0;
        tick(2);

        // Single request from requester 1
        req_vector[1*IN_WIDTH +: IN_WIDTH] = {16{8'hA5}};
        push_job(1, {16{8'hA5}}, 1'b1);
        done_delay = 20;
        s0 = start_count;
        a0 = ack_count;
        req = 4'b0010;
        t_start = cyc;
        wait_starts(s0 + 1, 10, "t1_start");
        check("t1_req_to_start", IN_WIDTH'(last_start_cyc - t_start), IN_WIDTH'(2));
        req_vector[1*IN_WIDTH +: IN_WIDTH] = '0;
        tick(5);
        check("t1_vector_held", shifter_vector, {16{8'hA5}});
        check("t1_busy", IN_WIDTH'(busy), IN_WIDTH'(1));
        wait_acks(a0 + 1, 40, "t1_ack");
        check("t1_start_to_ack", IN_WIDTH'(last_ack_cyc - last_start_cyc), IN_WIDTH'(21));
        tick(2);

        // Reset while waiting for done: no ack, and the late done is ignored
        req_vector[3*IN_WIDTH +: IN_WIDTH] = vec_of(3);
        push_job(3, vec_of(3), 1'b0);
        s0 = start_count;
        req = 4'b1000;
        wait_starts(s0 + 1, 10, "rst_start");
        tick(4);
        reset = 1'b1;
        tick(1);
        check("midrst_busy", IN_WIDTH'(busy), '0);
        check("midrst_start", IN_WIDTH'(shifter_start), '0);
        check("midrst_ack", IN_WIDTH'(ack), '0);
        check("midrst_grant_id", IN_WIDTH'(grant_id), '0);
        reset = 1'b0;
        req = '0;
        a0 = ack_count;
        tick(25);
        check("midrst_no_ack", IN_WIDTH'(ack_count), IN_WIDTH'(a0));
        check("midrst_idle", IN_WIDTH'(busy), '0);

        // All four requesting continuously from rr_ptr=0: 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) req_vector[i*IN_WIDTH +: IN_WIDTH] = vec_of(i);
        push_job(0, vec_of(0), 1'b1);
        push_job(1, vec_of(1), 1'b1);
        push_job(2, vec_of(2), 1'b1);
        push_job(3, vec_of(3), 1'b1);
        push_job(0, vec_of(0), 1'b1);
        done_delay = 3;
        s0 = start_count;
        a0 = ack_count;
        sticky = 4'b1111;
        req = 4'b1111;
        wait_starts(s0 + 5, 100, "all4_start");
        req = '0;
        sticky = '0;
        wait_acks(a0 + 5, 100, "all4_ack");
        tick(3);

        // Fairness: 0 held high, 2 requests once -> 0, 2, 0
        push_job(0, vec_of(0), 1'b1);
        s0 = start_count;
        a0 = ack_count;
        sticky = 4'b0001;
        req = 4'b0001;
        wait_starts(s0 + 1, 10, "fair_first");
        tick(1);
        push_job(2, vec_of(2), 1'b1);
        push_job(0, vec_of(0), 1'b1);
        req[2] = 1'b1;
        wait_starts(s0 + 3, 100, "fair_start");
        req[0] = 1'b0;
        sticky = '0;
        wait_acks(a0 + 3, 100, "fair_ack");
        tick(3);

        // Withdrawn request still completes
        push_job(3, vec_of(3), 1'b1);
        a0 = ack_count;
        req = 4'b1000;
        begin
            int i = 0;
            while (!busy && i < 10) begin
                tick(1);
                i++;
            end
            check("wd_grant_seen", IN_WIDTH'(busy), IN_WIDTH'(1));
        end
        tick(1);
        req[3] = 1'b0;
        wait_acks(a0 + 1, 40, "withdrawn_ack");
        tick(3);

`ifdef SHIFTER_ARB_TIMEOUT_EN
        // Watchdog: done withheld for requester 0; requester 1 then 0 again
        shifter_en = 1'b0;
        push_job(0, vec_of(0), 1'b0);
        push_job(1, vec_of(1), 1'b1);
        push_job(0, vec_of(0), 1'b1);
        s0 = start_count;
        a0 = ack_count;
        req = 4'b0011;
        wait_starts(s0 + 1, 10, "to_start");
        t_start = last_start_cyc;
        begin
            int i = 0;
            while (to_count == 0 && i < 40) begin
                tick(1);
                i++;
            end
        end
        check("to_seen", IN_WIDTH'(to_count), IN_WIDTH'(1));
        check("to_latency", IN_WIDTH'(last_to_cyc - t_start), IN_WIDTH'(TIMEOUT_CYCLES));
        check("to_no_ack", IN_WIDTH'(ack_count), IN_WIDTH'(a0));
        shifter_en = 1'b1;
        wait_acks(a0 + 2, 100, "to_after_ack");
        tick(3);
`endif

        check("scoreboard_empty", IN_WIDTH'(exp_start_q.size() + exp_ack_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
